switch_out_port_queue: RTL and testbench
========================================

// Module: switch_out_port_queue
// PURPOSE
//  Parametrised output-port queue for the switch: buffers words routed to one output
//  port and presents them on port_out / port_ready / port_read (read-pulled protocol).
//  Generalises the fixed 8-bit output port with configurable width/depth, backpressure,
//  drop reporting and flush. Sits between switch fabric (write side) and the port consumer.
// PARAMETERS
//  DATA_W    8    width of wr_data / port_out in bits
//  DEPTH     16   queue entries; power of two, >= 2
//  AFULL_LVL 14   level at/above which wr_afull asserts (1..DEPTH)
// PORTS
//  clk         in   1              single clock, all logic on posedge
//  rst         in   1              asynchronous, active-high reset
//  flush       in   1              sync clear of queue contents
//  wr_en       in   1              write request from fabric
//  wr_data     in   DATA_W         write word
//  wr_full     out  1              queue full (level == DEPTH)
//  wr_afull    out  1              level >= AFULL_LVL
//  wr_drop     out  1              1-cycle pulse: write rejected
//  port_out    out  DATA_W         head word, valid while port_ready
//  port_ready  out  1              head word available
//  port_read   in   1              consumer pops head at posedge when port_ready
//  level       out  $clog2(DEPTH)+1  current occupancy 0..DEPTH
//  drop_cnt    out  16             stats: rejected writes (see CONFIGURATION)
//  unf_cnt     out  16             stats: port_read while !port_ready
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers/level 0, port_ready 0, port_out 0,
//    wr_full 0, wr_afull 0, wr_drop 0, drop_cnt 0, unf_cnt 0.
//  - Storage: circular buffer, rd/wr pointers $clog2(DEPTH) bits wrap DEPTH-1 -> 0.
//  - Write accepted on posedge when wr_en && !flush && (level < DEPTH || pop).
//  - pop = port_read && port_ready. port_read while !port_ready: ignored (no state change).
//  - First-word-fall-through: port_out registered = mem[rd_ptr]; write into empty queue
//    -> port_ready=1 and port_out=word one cycle after accepting edge (latency 1).
//  - port_out holds stable while port_ready && !port_read; after pop updates next edge
//    to the new head, or port_ready drops to 0 if queue became empty.
//  - Simultaneous write+pop: level unchanged; at full the write is accepted (no drop).
//    At level 1 with write+pop: port_ready stays 1, port_out = new word next cycle.
//  - Overflow: wr_en at level==DEPTH without pop -> word discarded, wr_drop=1 next cycle
//    for one cycle, contents untouched.
//  - wr_full, wr_afull, level registered, reflect state after each edge.
//  - flush: next edge level=0, pointers 0, port_ready=0; overrides same-cycle wr_en/
//    port_read (no drop pulse, no counter change). Stats counters not cleared by flush.
//  - Reset mid-operation: contents lost, all outputs to reset values immediately.
// CONFIGURATION
//  OUT_PORT_STATS_EN defined: drop_cnt +1 per wr_drop; unf_cnt +1 per port_read with
//   !port_ready (flush cycles excluded); both saturate at 16'hFFFF, cleared only by rst.
//  OUT_PORT_STATS_EN undefined: counter logic absent; drop_cnt, unf_cnt tied to 0.
//  All other behaviour identical in both builds.
// TESTING
//  1 DEPTH=16: write 0x01..0x10, no reads -> level 16, wr_full=1, wr_afull=1 from level 14;
//    then pop 16x -> bytes 0x01..0x10 in order, port_ready=0, level 0.
//  2 Full queue, wr_en with 0xAA, no read -> wr_drop 1 cycle, level 16, drop_cnt=1 (STATS).
//  3 Full queue, wr_en 0x55 + port_read same cycle -> no drop, head advances, level 16,
//    0x55 read last.
//  4 Empty queue: port_read 3 cycles -> no state change, unf_cnt=3 (STATS) / 0 (no STATS);
//    single write 0x3C -> port_ready=1, port_out=0x3C one cycle later.
//  5 Level 5, flush + wr_en + port_read same cycle -> level 0, port_ready 0, no wr_drop.
//  6 Level 7, assert rst mid-cycle -> outputs 0 immediately; after release write 0x11
//    -> port_out 0x11 (wrap check: run 40 writes/reads through DEPTH=16, data in order).

Source files
------------

// File: rtl/switch_out_port_queue.sv
// Output-port queue: circular buffer with first-word-fall-through head register,
// overflow drop reporting and flush. Define OUT_PORT_STATS_EN to enable drop/underflow counters.
module switch_out_port_queue #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 14
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_full,
    output logic                       wr_afull,
    output logic                       wr_drop,
    output logic [DATA_W-1:0]          port_out,
    output logic                       port_ready,
    input  logic                       port_read,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                drop_cnt,
    output logic [15:0]                unf_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_L = LW'(AFULL_LVL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr, rd_n, wr_n;
    logic [LW-1:0]     lvl_n;
    logic [DATA_W-1:0] head_n;
    logic              pop, push, drop;

    // Handshake: the consumer pops the head on a posedge where port_read && port_ready;
    // the fabric's write is taken unless the queue is full and not popping that same edge.
    always_comb begin
        pop    = port_read && port_ready;
        push   = wr_en && !flush && ((level != DEPTH_L) || pop);
        drop   = wr_en && !flush && (level == DEPTH_L) && !pop;
        rd_n   = pop  ? rd_ptr + AW'(1) : rd_ptr;
        wr_n   = push ? wr_ptr + AW'(1) : wr_ptr;
        lvl_n  = level + LW'(push) - LW'(pop);
        // When the queue drains to nothing this edge, the incoming word becomes the head.
        head_n = (push && (level == LW'(pop))) ? wr_data : mem[rd_n];
        if (flush) begin
            rd_n  = '0;
            wr_n  = '0;
            lvl_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            port_ready <= 1'b0;
            port_out   <= '0;
            wr_full    <= 1'b0;
            wr_afull   <= 1'b0;
            wr_drop    <= 1'b0;
        end else begin
            rd_ptr     <= rd_n;
            wr_ptr     <= wr_n;
            level      <= lvl_n;
            port_ready <= (lvl_n != '0);
            wr_full    <= (lvl_n == DEPTH_L);
            wr_afull   <= (lvl_n >= AFULL_L);
            wr_drop    <= drop;
            if (lvl_n != '0) port_out <= head_n;
        end
    end

`ifdef OUT_PORT_STATS_EN
    logic unf;
    assign unf = port_read && !port_ready && !flush;

    // Saturating statistics, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
            unf_cnt  <= '0;
        end else begin
            if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
            if (unf && (unf_cnt != 16'hFFFF))   unf_cnt  <= unf_cnt + 16'd1;
        end
    end
`else
    assign drop_cnt = '0;
    assign unf_cnt  = '0;
`endif

endmodule

// File: tb/tb_switch_out_port_queue.sv
// Bench for switch_out_port_queue: directed scenarios plus randomized traffic against a queue model.
module tb_switch_out_port_queue;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        port_read = 1'b0;
    logic        wr_full, wr_afull, wr_drop, port_ready;
    logic [7:0]  port_out;
    logic [4:0]  level;
    logic [15:0] drop_cnt, unf_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    bit         exp_drop;
    int         exp_drop_cnt, exp_unf_cnt;

    switch_out_port_queue #(.DATA_W(8), .DEPTH(DEPTH), .AFULL_LVL(14)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(wr_full), .wr_afull(wr_afull), .wr_drop(wr_drop),
        .port_out(port_out), .port_ready(port_ready), .port_read(port_read),
        .level(level), .drop_cnt(drop_cnt), .unf_cnt(unf_cnt)
    );

    always #5 clk = ~clk;

    // One clock edge with current inputs; the model is advanced from the behavioural rules.
    task automatic cycle();
        bit pop, push, unf;
        pop      = port_read && (exp_q.size() > 0);
        push     = wr_en && !flush && ((exp_q.size() < DEPTH) || pop);
        exp_drop = wr_en && !flush && (exp_q.size() == DEPTH) && !pop;
        unf      = port_read && (exp_q.size() == 0) && !flush;
        @(posedge clk);
        if (flush) exp_q.delete();
        else begin
            if (pop) void'(exp_q.pop_front());
            if (push) exp_q.push_back(wr_data);
        end
`ifdef OUT_PORT_STATS_EN
        if (exp_drop && exp_drop_cnt < 65535) exp_drop_cnt++;
        if (unf && exp_unf_cnt < 65535) exp_unf_cnt++;
`endif
        #1;
    endtask

    task automatic idle();
        wr_en = 0; port_read = 0; flush = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle();
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete(); exp_drop = 0; exp_drop_cnt = 0; exp_unf_cnt = 0;
        n_tests++;
        if ({level, port_ready, port_out, wr_full, wr_afull, wr_drop} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: level=%0d ready=%b out=%h full=%b afull=%b drop=%b, required all 0",
                     level, port_ready, port_out, wr_full, wr_afull, wr_drop);
        end
        n_tests++;
        if (drop_cnt !== 16'd0 || unf_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: drop_cnt=%0d unf_cnt=%0d, required 0", drop_cnt, unf_cnt);
        end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            wr_en = 1; wr_data = 8'(i); port_read = 0;
            cycle();
            n_tests++;
            if (level !== 5'(i) || wr_afull !== (i >= 14) || wr_full !== (i == DEPTH)) begin
                n_fail++;
                $display("FAIL fill_flags[%0d]: level=%0d afull=%b full=%b, required level=%0d afull=%b full=%b",
                         i, level, wr_afull, wr_full, i, (i >= 14), (i == DEPTH));
            end
        end
        idle();
        for (int i = 1; i <= DEPTH; i++) begin
            n_tests++;
            if (port_ready !== 1'b1 || port_out !== 8'(i)) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: ready=%b out=%h, required ready=1 out=%h", i, port_ready, port_out, 8'(i));
            end
            port_read = 1;
            cycle();
        end
        idle();
        n_tests++;
        if (port_ready !== 1'b0 || level !== 5'd0 || wr_full !== 1'b0 || wr_afull !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: ready=%b level=%0d full=%b afull=%b, required 0 0 0 0", port_ready, level, wr_full, wr_afull);
        end
    endtask

    task automatic fill(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            wr_en = 1; port_read = 0; flush = 0; wr_data = base + 8'(i);
            cycle();
        end
        idle();
    endtask

    task automatic test_overflow();
        fill(DEPTH, 8'h20);
        wr_en = 1; wr_data = 8'hAA;
        cycle();
        idle();
        n_tests++;
        if (wr_drop !== 1'b1 || level !== 5'd16 || drop_cnt !== 16'(exp_drop_cnt)) begin
            n_fail++;
            $display("FAIL overflow_drop: drop=%b level=%0d drop_cnt=%0d, required 1 16 %0d", wr_drop, level, drop_cnt, exp_drop_cnt);
        end
        cycle();
        n_tests++;
        if (wr_drop !== 1'b0 || port_out !== 8'h20) begin
            n_fail++;
            $display("FAIL overflow_pulse: drop=%b head=%h, required drop=0 head=20", wr_drop, port_out);
        end
    endtask

    task automatic test_full_write_pop();
        wr_en = 1; wr_data = 8'h55; port_read = 1;
        cycle();
        idle();
        n_tests++;
        if (wr_drop !== 1'b0 || level !== 5'd16 || port_out !== 8'h21) begin
            n_fail++;
            $display("FAIL full_wr_pop: drop=%b level=%0d head=%h, required 0 16 21", wr_drop, level, port_out);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_tests++;
            if (port_out !== exp_q[0]) begin
                n_fail++;
                $display("FAIL full_drain[%0d]: out=%h, required %h", i, port_out, exp_q[0]);
            end
            if (i == DEPTH - 1) begin
                n_tests++;
                if (port_out !== 8'h55) begin
                    n_fail++;
                    $display("FAIL full_last_word: out=%h, required 55", port_out);
                end
            end
            port_read = 1;
            cycle();
        end
        idle();
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 3; i++) begin
            port_read = 1;
            cycle();
        end
        idle();
        n_tests++;
        if (level !== 5'd0 || port_ready !== 1'b0 || unf_cnt !== 16'(exp_unf_cnt)) begin
            n_fail++;
            $display("FAIL underflow: level=%0d ready=%b unf_cnt=%0d, required 0 0 %0d", level, port_ready, unf_cnt, exp_unf_cnt);
        end
        wr_en = 1; wr_data = 8'h3C;
        cycle();
        idle();
        n_tests++;
        if (port_ready !== 1'b1 || port_out !== 8'h3C || level !== 5'd1) begin
            n_fail++;
            $display("FAIL single_write: ready=%b out=%h level=%0d, required 1 3c 1", port_ready, port_out, level);
        end
        port_read = 1;
        cycle();
        idle();
    endtask

    task automatic test_flush();
        fill(5, 8'h40);
        flush = 1; wr_en = 1; wr_data = 8'h99; port_read = 1;
        cycle();
        idle();
        n_tests++;
        if (level !== 5'd0 || port_ready !== 1'b0 || wr_drop !== 1'b0 || unf_cnt !== 16'(exp_unf_cnt) || drop_cnt !== 16'(exp_drop_cnt)) begin
            n_fail++;
            $display("FAIL flush: level=%0d ready=%b drop=%b unf=%0d dcnt=%0d, required 0 0 0 %0d %0d",
                     level, port_ready, wr_drop, unf_cnt, drop_cnt, exp_unf_cnt, exp_drop_cnt);
        end
    endtask

    task automatic test_reset_mid_wrap();
        fill(7, 8'h60);
        @(posedge clk);
        #3 rst = 1;
        #1;
        exp_q.delete(); exp_drop_cnt = 0; exp_unf_cnt = 0;
        n_tests++;
        if ({level, port_ready, port_out, wr_full, wr_afull, wr_drop, drop_cnt, unf_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: level=%0d ready=%b out=%h full=%b afull=%b drop=%b, required all 0",
                     level, port_ready, port_out, wr_full, wr_afull, wr_drop);
        end
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        wr_en = 1; wr_data = 8'h11;
        cycle();
        idle();
        n_tests++;
        if (port_ready !== 1'b1 || port_out !== 8'h11) begin
            n_fail++;
            $display("FAIL post_reset_write: ready=%b out=%h, required 1 11", port_ready, port_out);
        end
        // 40 words streamed one-in one-out forces several pointer wraps.
        for (int i = 0; i < 40; i++) begin
            n_tests++;
            if (port_out !== exp_q[0]) begin
                n_fail++;
                $display("FAIL wrap[%0d]: out=%h, required %h", i, port_out, exp_q[0]);
            end
            wr_en = 1; wr_data = 8'(8'h80 + i); port_read = 1;
            cycle();
        end
        idle();
        n_tests++;
        if (level !== 5'd1 || port_out !== 8'(8'h80 + 39)) begin
            n_fail++;
            $display("FAIL wrap_end: level=%0d out=%h, required 1 %h", level, port_out, 8'(8'h80 + 39));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            wr_en     = ($urandom_range(99) < 60);
            wr_data   = 8'($urandom);
            port_read = ($urandom_range(99) < 45);
            flush     = ($urandom_range(99) < 3);
            cycle();
            n_tests++;
            if (level !== 5'(exp_q.size()) || port_ready !== (exp_q.size() > 0) ||
                wr_full !== (exp_q.size() == DEPTH) || wr_afull !== (exp_q.size() >= 14) ||
                wr_drop !== exp_drop || (exp_q.size() > 0 && port_out !== exp_q[0]) ||
                drop_cnt !== 16'(exp_drop_cnt) || unf_cnt !== 16'(exp_unf_cnt)) begin
                n_fail++;
                $display("FAIL random[%0d]: level=%0d/%0d ready=%b out=%h/%h full=%b afull=%b drop=%b/%b dcnt=%0d/%0d ucnt=%0d/%0d",
                         i, level, exp_q.size(), port_ready, port_out, (exp_q.size() > 0) ? exp_q[0] : 8'h00,
                         wr_full, wr_afull, wr_drop, exp_drop, drop_cnt, exp_drop_cnt, unf_cnt, exp_unf_cnt);
            end
        end
        idle();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_write_pop();
        test_underflow();
        test_flush();
        test_reset_mid_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
